// File: rtl/dmem_loader_pkg.sv
// Shared definitions for the data-memory preload engine: FSM encoding and
// word geometry used by the loader and its byte packer.
package dmem_loader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_FINISH = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  localparam int BYTES_PER_WORD = 4;
  localparam int BYTE_IDX_W     = $clog2(BYTES_PER_WORD);

endpackage

// File: rtl/dmem_loader_byte_packer.sv
// Packs a byte stream into 32-bit big-endian words; word_valid_o flags the
// cycle in which the fourth byte is presented so the word can be registered.
module byte_packer
  import dmem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear_i,
  input  logic        byte_valid_i,
  input  logic [7:0]  byte_i,
  output logic        word_valid_o,
  output logic [31:0] word_o
);

  localparam logic [BYTE_IDX_W-1:0] LAST_IDX = BYTE_IDX_W'(BYTES_PER_WORD - 1);

  logic [BYTE_IDX_W-1:0] idx_q, idx_d;
  // First three bytes of the word in arrival order; the fourth comes straight from byte_i.
  logic [23:0]           head_q, head_d;

  assign word_valid_o = byte_valid_i && (idx_q == LAST_IDX);
  assign word_o       = {head_q, byte_i};

  always_comb begin
    idx_d  = idx_q;
    head_d = head_q;
    if (clear_i) begin
      idx_d  = '0;
      head_d = '0;
    end else if (byte_valid_i) begin
      idx_d  = idx_q + BYTE_IDX_W'(1);
      head_d = {head_q[15:0], byte_i};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q  <= '0;
      head_q <= '0;
    end else begin
      idx_q  <= idx_d;
      head_q <= head_d;
    end
  end

endmodule

// File: rtl/dmem_loader.sv
// Data-memory preload engine: streams NUM_WORDS big-endian words into data
// memory from address 0 and holds the CPU in reset until the last write.
module dmem_loader
  import dmem_loader_pkg::*;
#(
  parameter int NUM_WORDS  = 25,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  in_valid,
  input  logic [7:0]            in_data,
  output logic                  in_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic                  cpu_reset,
  output logic                  busy,
  output logic                  done,
  output logic [31:0]           checksum,
  output state_e                state_dbg
);

  // Handshake: a byte transfers on a rising edge where in_valid && in_ready;
  // in_ready is registered and high exactly while the FSM is in LOAD.

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_WORDS - 1);

  state_e                state_q, state_d;
  logic                  in_ready_q;
  logic                  mem_we_q;
  logic [ADDR_WIDTH-1:0] mem_addr_q;
  logic [31:0]           mem_wdata_q;
  logic                  cpu_reset_q;
  logic                  busy_q;
  logic                  done_q;
  logic [31:0]           checksum_q;
  logic [ADDR_WIDTH-1:0] word_cnt_q;

  logic                  accept;
  logic                  start_load;
  logic                  word_valid;
  logic [31:0]           word;
  logic                  last_word;

  assign accept     = in_valid && in_ready_q;
  assign start_load = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
  assign last_word  = (word_cnt_q == LAST_ADDR);

  byte_packer u_packer (
    .clk          (clk),
    .rst          (reset),
    .clear_i      (start_load),
    .byte_valid_i (accept),
    .byte_i       (in_data),
    .word_valid_o (word_valid),
    .word_o       (word)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (start) state_d = ST_LOAD;
      ST_LOAD:   if (word_valid && last_word) state_d = ST_FINISH;
      ST_FINISH: state_d = ST_DONE;
      ST_DONE:   if (start) state_d = ST_LOAD;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      in_ready_q  <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      cpu_reset_q <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      checksum_q  <= '0;
      word_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= (state_d == ST_LOAD);
      busy_q      <= (state_d == ST_LOAD) || (state_d == ST_FINISH);
      done_q      <= (state_d == ST_DONE);
      cpu_reset_q <= (state_d != ST_DONE);
      mem_we_q    <= word_valid;
      if (start_load) begin
        word_cnt_q <= '0;
        checksum_q <= '0;
        mem_addr_q <= '0;
      end else if (word_valid) begin
        mem_addr_q  <= word_cnt_q;
        mem_wdata_q <= word;
        checksum_q  <= checksum_q + word;
        // The counter parks on the last address so it can never wrap.
        if (!last_word) word_cnt_q <= word_cnt_q + ADDR_WIDTH'(1);
      end
    end
  end

  assign in_ready  = in_ready_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign cpu_reset = cpu_reset_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign checksum  = checksum_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_dmem_loader.sv
// Bench for dmem_loader: table-driven word vectors plus hand-written runs,
// with a scoreboard queue of expected {address, word} writes.
module tb_dmem_loader;
  import dmem_loader_pkg::*;

  localparam int NW = 25;
  localparam int AW = 5;
  localparam int EW = AW + 32;

  logic          clk;
  logic          reset;
  logic          start;
  logic          in_valid;
  logic [7:0]    in_data;
  logic          in_ready;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic          cpu_reset;
  logic          busy;
  logic          done;
  logic [31:0]   checksum;
  state_e        state_dbg;

  dmem_loader #(.NUM_WORDS(NW), .ADDR_WIDTH(AW)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .cpu_reset (cpu_reset),
    .busy      (busy),
    .done      (done),
    .checksum  (checksum),
    .state_dbg (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- checking ----------------
  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- scoreboard ----------------
  logic [EW-1:0] exp_q[$];
  int wr_cnt        = 0;
  int last_we_cyc   = 0;
  int done_rise_cyc = 0;
  int cpu_fall_cyc  = 0;
  bit prev_we       = 1'b0;
  bit prev_done     = 1'b0;
  bit prev_cpu_rst  = 1'b1;

  always @(negedge clk) begin
    logic [EW-1:0] e;
    if (mem_we) begin
      wr_cnt++;
      last_we_cyc = cyc;
      check("we_one_cycle", 64'(prev_we), 64'd0);
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_write: addr %0d data %0h with no write expected", mem_addr, mem_wdata);
      end else begin
        e = exp_q.pop_front();
        check("wr_addr", 64'(mem_addr), 64'(e[EW-1:32]));
        check("wr_data", 64'(mem_wdata), 64'(e[31:0]));
      end
    end
    if (done && !prev_done) done_rise_cyc = cyc;
    if (!cpu_reset && prev_cpu_rst) cpu_fall_cyc = cyc;
    prev_we      = mem_we;
    prev_done    = done;
    prev_cpu_rst = cpu_reset;
  end

  // ---------------- driver tasks ----------------
  int          widx         = 0;
  logic [31:0] sum_model    = '0;
  int          first_acc_cyc = 0;
  bit          first_seen   = 1'b0;

  task automatic begin_run();
    widx       = 0;
    sum_model  = '0;
    first_seen = 1'b0;
    wr_cnt     = 0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int guard;
    guard    = 0;
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) check("in_ready_timeout", 64'(in_ready), 64'd1);
    @(posedge clk);
    @(negedge clk);
    if (!first_seen) begin
      first_seen    = 1'b1;
      first_acc_cyc = cyc;
    end
    in_valid = 1'b0;
  endtask

  task automatic send4(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                       input logic [7:0] b3, input logic [31:0] exp_w, input int gap);
    exp_q.push_back({AW'(widx), exp_w});
    widx++;
    sum_model = sum_model + exp_w;
    send_byte(b0); repeat (gap) @(negedge clk);
    send_byte(b1); repeat (gap) @(negedge clk);
    send_byte(b2); repeat (gap) @(negedge clk);
    send_byte(b3); repeat (gap) @(negedge clk);
  endtask

  task automatic send_word(input logic [31:0] w, input int gap);
    send4(w[31:24], w[23:16], w[15:8], w[7:0], w, gap);
  endtask

  task automatic wait_done();
    int guard;
    guard = 0;
    while (!done && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    #1;
    check("done_timeout", 64'(done), 64'd1);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_in_ready"},  64'(in_ready),  64'd0);
    check({tag, "_mem_we"},    64'(mem_we),    64'd0);
    check({tag, "_cpu_reset"}, 64'(cpu_reset), 64'd1);
    check({tag, "_busy"},      64'(busy),      64'd0);
    check({tag, "_done"},      64'(done),      64'd0);
    check({tag, "_mem_addr"},  64'(mem_addr),  64'd0);
    check({tag, "_mem_wdata"}, 64'(mem_wdata), 64'd0);
    check({tag, "_checksum"},  64'(checksum),  64'd0);
    check({tag, "_state"},     64'(state_dbg), 64'(ST_IDLE));
  endtask

  // ---------------- vector table ----------------
  typedef struct packed {
    logic [7:0]  b0;
    logic [7:0]  b1;
    logic [7:0]  b2;
    logic [7:0]  b3;
    logic [31:0] exp_w;
  } vec_t;

  vec_t vecs[6];

  // ---------------- watchdog ----------------
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog expired");
  end

  // ---------------- main sequence ----------------
  initial begin
    vecs[0] = '{8'h12, 8'h34, 8'h56, 8'h78, 32'h12345678};
    vecs[1] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 32'hFFFFFFFF};
    vecs[2] = '{8'h00, 8'h00, 8'h00, 8'h00, 32'h00000000};
    vecs[3] = '{8'h80, 8'h00, 8'h00, 8'h01, 32'h80000001};
    vecs[4] = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 32'hDEADBEEF};
    vecs[5] = '{8'h01, 8'h02, 8'h03, 8'h04, 32'h01020304};

    reset    = 1'b1;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    repeat (2) @(negedge clk);
    check_reset_values("rst");
    reset = 1'b0;
    @(negedge clk);

    // Input offered in IDLE without start must be ignored.
    in_valid = 1'b1;
    in_data  = 8'hA5;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("idle_in_ready",  64'(in_ready),  64'd0);
      check("idle_mem_we",    64'(mem_we),    64'd0);
      check("idle_cpu_reset", 64'(cpu_reset), 64'd1);
    end
    in_valid = 1'b0;

    // Run A: back-to-back words 25..1.
    begin_run();
    pulse_start();
    check("load_in_ready", 64'(in_ready), 64'd1);
    check("load_busy",     64'(busy),     64'd1);
    check("load_state",    64'(state_dbg), 64'(ST_LOAD));
    for (int i = 0; i < NW; i++) send_word(32'(NW - i), 0);
    wait_done();
    // Edges from the first accepting edge to the done edge, both inclusive.
    check("a_load_cycles",   64'(done_rise_cyc - first_acc_cyc + 1), 64'(4 * NW + 1));
    check("a_done_after_we", 64'(done_rise_cyc), 64'(last_we_cyc + 1));
    check("a_cpu_rst_fall",  64'(cpu_fall_cyc),  64'(last_we_cyc + 1));
    check("a_checksum",      64'(checksum), 64'd325);
    check("a_checksum_model", 64'(checksum), 64'(sum_model));
    check("a_writes",        64'(wr_cnt), 64'(NW));
    check("a_busy",          64'(busy), 64'd0);
    check("a_state",         64'(state_dbg), 64'(ST_DONE));

    // DONE holds and ignores offered bytes.
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("done_hold",     64'(done),     64'd1);
      check("done_in_ready", 64'(in_ready), 64'd0);
      check("done_mem_we",   64'(mem_we),   64'd0);
    end
    in_valid = 1'b0;

    // Run B: restart from DONE, one idle cycle between bytes, start pulsed mid-load.
    begin_run();
    pulse_start();
    check("restart_done",      64'(done),      64'd0);
    check("restart_cpu_reset", 64'(cpu_reset), 64'd1);
    check("restart_checksum",  64'(checksum),  64'd0);
    check("restart_mem_addr",  64'(mem_addr),  64'd0);
    for (int i = 0; i < NW; i++) begin
      send_word(32'(NW - i), 1);
      if (i == 10) pulse_start();
    end
    wait_done();
    check("b_checksum", 64'(checksum), 64'd325);
    check("b_writes",   64'(wr_cnt), 64'(NW));
    check("b_queue",    64'(exp_q.size()), 64'd0);

    // Run C: reset after 10 bytes (two words written, two bytes pending).
    begin_run();
    pulse_start();
    send_word(32'hCAFE0001, 0);
    send_word(32'hCAFE0002, 0);
    send_byte(8'h77);
    send_byte(8'h88);
    reset = 1'b1;
    #1;
    check_reset_values("midrst");
    check("c_writes", 64'(wr_cnt), 64'd2);
    check("c_queue",  64'(exp_q.size()), 64'd0);
    repeat (2) begin
      @(negedge clk);
      check("midrst_no_we", 64'(mem_we), 64'd0);
    end
    reset = 1'b0;
    @(negedge clk);
    check("c_after_rst_state", 64'(state_dbg), 64'(ST_IDLE));

    // Run D: fresh load, table vectors first, random words after.
    begin_run();
    pulse_start();
    for (int i = 0; i < 6; i++)
      send4(vecs[i].b0, vecs[i].b1, vecs[i].b2, vecs[i].b3, vecs[i].exp_w, 0);
    for (int i = 6; i < NW; i++) send_word($urandom(), 0);
    wait_done();
    check("d_checksum",  64'(checksum),  64'(sum_model));
    check("d_writes",    64'(wr_cnt),    64'(NW));
    check("d_cpu_reset", 64'(cpu_reset), 64'd0);
    check("d_queue",     64'(exp_q.size()), 64'd0);

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
